// File: rtl/hazard_pkg.sv
// hazard_pkg: shared encodings for the pipeline hazard controller
package hazard_pkg;
  typedef enum logic [1:0] {RUN = 2'd0, WAIT_I = 2'd1, WAIT_D = 2'd2, REDIRECT = 2'd3} state_t;
  localparam logic [1:0] FWD_RF = 2'd0;
  localparam logic [1:0] FWD_EX = 2'd1;
  localparam logic [1:0] FWD_MEM = 2'd2;
  localparam logic [1:0] FWD_WB = 2'd3;
  localparam logic [1:0] CTL_NONE = 2'd0;
  localparam logic [1:0] CTL_BR = 2'd1;
  localparam logic [1:0] CTL_J = 2'd2;
  localparam logic [1:0] CTL_JR = 2'd3;
  localparam logic [1:0] BTB_BR = 2'd0;
  localparam logic [1:0] BTB_JR = 2'd1;
  localparam logic [1:0] BTB_J = 2'd2;
  localparam logic [1:0] BTB_NEXT = 2'd3;
endpackage

// File: rtl/hazard_fwd_sel.sv
// hazard_fwd_sel: picks the youngest in-flight producer of one source operand
module hazard_fwd_sel
  import hazard_pkg::*;
#(
  parameter int RA_W = 2
) (
  input  logic            use_src,
  input  logic [RA_W-1:0] src,
  input  logic [RA_W-1:0] ex_dest,
  input  logic [RA_W-1:0] m_dest,
  input  logic [RA_W-1:0] wb_dest,
  input  logic            ex_regwrite,
  input  logic            ex_is_load,
  input  logic            m_regwrite,
  input  logic            wb_regwrite,
  output logic [1:0]      sel
);
  // a load in EX has no data yet, so it can only be forwarded from MEM onwards
  always_comb
    sel = !use_src ? FWD_RF :
          (ex_regwrite && !ex_is_load && src == ex_dest) ? FWD_EX :
          (m_regwrite && src == m_dest) ? FWD_MEM :
          (wb_regwrite && src == wb_dest) ? FWD_WB : FWD_RF;
endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl: stall/flush/forward/BTB control with cache-miss FSM (HAZARD_PERF_CNT_EN adds perf counters)
module pipeline_hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int WORD_W = 16,
  parameter int RA_W = 2,
  parameter int PERF_W = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [RA_W-1:0]   id_rs,
  input  logic [RA_W-1:0]   id_rt,
  input  logic              id_use_rs,
  input  logic              id_use_rt,
  input  logic [1:0]        id_ctl,
  input  logic [RA_W-1:0]   ex_dest,
  input  logic [RA_W-1:0]   m_dest,
  input  logic [RA_W-1:0]   wb_dest,
  input  logic              ex_regwrite,
  input  logic              m_regwrite,
  input  logic              wb_regwrite,
  input  logic              ex_is_load,
  input  logic              bcond,
  input  logic [WORD_W-1:0] predicted_pc,
  input  logic [WORD_W-1:0] next_pc,
  input  logic [WORD_W-1:0] br_target,
  input  logic [WORD_W-1:0] jump_addr,
  input  logic [WORD_W-1:0] jr_target,
  input  logic              i_cache_hit,
  input  logic              i_ready,
  input  logic              d_req,
  input  logic              d_cache_hit,
  input  logic              d_ready,
  output logic              pc_write,
  output logic              id_write,
  output logic              ex_write,
  output logic              m_write,
  output logic              wb_write,
  output logic              ex_bubble,
  output logic              flush,
  output logic              redirect_valid,
  output logic [WORD_W-1:0] redirect_pc,
  output logic              btb_write,
  output logic [1:0]        btb_src,
  output logic              is_predict,
  output logic [1:0]        fwd_a,
  output logic [1:0]        fwd_b,
  output logic [1:0]        state,
  output logic [PERF_W-1:0] stall_cycles,
  output logic [PERF_W-1:0] flush_count
);
  state_t state_q, state_d;
  logic pend, pend_d, d_busy, d_busy_d, i_done, i_done_d;
  logic [WORD_W-1:0] pend_pc, pend_pc_d, actual;
  logic d_miss, load_use, mispredict, resolve, back_w;
  logic [1:0] sel_a, sel_b;
  hazard_fwd_sel #(.RA_W(RA_W)) u_fwd_a (
    .use_src(id_use_rs), .src(id_rs), .ex_dest(ex_dest), .m_dest(m_dest), .wb_dest(wb_dest),
    .ex_regwrite(ex_regwrite), .ex_is_load(ex_is_load), .m_regwrite(m_regwrite),
    .wb_regwrite(wb_regwrite), .sel(sel_a)
  );
  hazard_fwd_sel #(.RA_W(RA_W)) u_fwd_b (
    .use_src(id_use_rt), .src(id_rt), .ex_dest(ex_dest), .m_dest(m_dest), .wb_dest(wb_dest),
    .ex_regwrite(ex_regwrite), .ex_is_load(ex_is_load), .m_regwrite(m_regwrite),
    .wb_regwrite(wb_regwrite), .sel(sel_b)
  );
  assign d_miss = d_req && !d_cache_hit;
  assign load_use = ex_is_load && ex_regwrite &&
                    ((id_use_rs && id_rs == ex_dest) || (id_use_rt && id_rt == ex_dest));
  assign actual = id_ctl == CTL_BR ? (bcond ? br_target : next_pc) :
                  id_ctl == CTL_J ? jump_addr : jr_target;
  assign mispredict = id_ctl != CTL_NONE && predicted_pc != actual;
  assign {ex_write, m_write, wb_write} = {3{back_w}};
  assign fwd_a = reset_n ? sel_a : FWD_RF;
  assign fwd_b = reset_n ? sel_b : FWD_RF;
  assign is_predict = reset_n && id_ctl != CTL_NONE;
  assign btb_write = resolve && (id_ctl == CTL_J || id_ctl == CTL_JR || (id_ctl == CTL_BR && bcond));
  assign btb_src = !resolve ? BTB_BR :
                   id_ctl == CTL_BR ? (bcond ? BTB_BR : BTB_NEXT) :
                   id_ctl == CTL_JR ? BTB_JR :
                   id_ctl == CTL_J ? BTB_J : BTB_BR;
  assign state = state_q;
  // next-state and pipeline controls; defaults are also the values forced during reset
  always_comb begin
    state_d = state_q;
    pend_d = pend;
    pend_pc_d = pend_pc;
    d_busy_d = d_busy;
    i_done_d = i_done;
    pc_write = 1'b1;
    id_write = 1'b1;
    back_w = 1'b1;
    ex_bubble = 1'b0;
    flush = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc = '0;
    resolve = 1'b0;
    if (reset_n) begin
      case (state_q)
        RUN: begin
          if (d_miss) begin
            {pc_write, id_write, back_w} = 3'b000;
            state_d = WAIT_D;
          end else if (load_use) begin
            {pc_write, id_write, ex_bubble} = 3'b001;
          end else begin
            resolve = 1'b1;
            if (mispredict && i_cache_hit) begin
              {flush, redirect_valid} = 2'b11;
              redirect_pc = actual;
            end else if (mispredict) begin
              {pend_d, flush, pc_write} = 3'b110;
              pend_pc_d = actual;
              state_d = WAIT_I;
            end else if (!i_cache_hit) begin
              {pc_write, id_write, ex_bubble} = 3'b001;
              state_d = WAIT_I;
            end
          end
        end
        WAIT_I: begin
          {pc_write, id_write, ex_bubble} = 3'b001;
          if (d_busy || d_miss) begin
            back_w = 1'b0;
            d_busy_d = d_busy ? !d_ready : 1'b1;
            i_done_d = i_done || i_ready;
          end else if (i_ready || i_done) begin
            i_done_d = 1'b0;
            state_d = pend ? REDIRECT : RUN;
          end
        end
        WAIT_D: begin
          {pc_write, id_write, back_w} = 3'b000;
          state_d = d_ready ? RUN : WAIT_D;
        end
        REDIRECT: begin
          {flush, redirect_valid, pend_d} = 3'b110;
          redirect_pc = pend_pc;
          state_d = RUN;
        end
        default: state_d = RUN;
      endcase
    end
  end
  // FSM and miss bookkeeping registers
  always_ff @(posedge clk)
    if (!reset_n) begin
      state_q <= RUN;
      pend <= 1'b0;
      pend_pc <= '0;
      d_busy <= 1'b0;
      i_done <= 1'b0;
    end else begin
      state_q <= state_d;
      pend <= pend_d;
      pend_pc <= pend_pc_d;
      d_busy <= d_busy_d;
      i_done <= i_done_d;
    end
`ifdef HAZARD_PERF_CNT_EN
  logic [PERF_W-1:0] stall_q, flush_q;
  // saturating stall and flush counters
  always_ff @(posedge clk)
    if (!reset_n) begin
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      if (!pc_write && !(&stall_q)) stall_q <= stall_q + PERF_W'(1);
      if (flush && !(&flush_q)) flush_q <= flush_q + PERF_W'(1);
    end
  assign stall_cycles = stall_q;
  assign flush_count = flush_q;
`else
  assign stall_cycles = '0;
  assign flush_count = '0;
`endif
endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// tb_pipeline_hazard_ctrl: directed plus randomized checks against a flag-based reference model
module tb_pipeline_hazard_ctrl;
  logic clk = 1'b0, reset_n;
  logic [1:0] id_rs, id_rt, ex_dest, m_dest, wb_dest, id_ctl;
  logic id_use_rs, id_use_rt, ex_regwrite, m_regwrite, wb_regwrite, ex_is_load, bcond;
  logic [15:0] predicted_pc, next_pc, br_target, jump_addr, jr_target;
  logic i_cache_hit, i_ready, d_req, d_cache_hit, d_ready;
  logic pc_write, id_write, ex_write, m_write, wb_write, ex_bubble, flush, redirect_valid;
  logic [15:0] redirect_pc, stall_cycles, flush_count;
  logic btb_write, is_predict;
  logic [1:0] btb_src, fwd_a, fwd_b, state;
  int n_chk = 0, n_pass = 0;
  bit w_i, w_d, redir, frz, iseen, pv, n_w_i, n_w_d, n_redir, n_frz, n_iseen, n_pv;
  logic [15:0] pt, n_pt;
  int stall = 0, fl = 0, n_stall, n_fl;

  pipeline_hazard_ctrl #(.WORD_W(16), .RA_W(2), .PERF_W(16)) dut (
    .clk(clk), .reset_n(reset_n), .id_rs(id_rs), .id_rt(id_rt), .id_use_rs(id_use_rs),
    .id_use_rt(id_use_rt), .id_ctl(id_ctl), .ex_dest(ex_dest), .m_dest(m_dest), .wb_dest(wb_dest),
    .ex_regwrite(ex_regwrite), .m_regwrite(m_regwrite), .wb_regwrite(wb_regwrite),
    .ex_is_load(ex_is_load), .bcond(bcond), .predicted_pc(predicted_pc), .next_pc(next_pc),
    .br_target(br_target), .jump_addr(jump_addr), .jr_target(jr_target),
    .i_cache_hit(i_cache_hit), .i_ready(i_ready), .d_req(d_req), .d_cache_hit(d_cache_hit),
    .d_ready(d_ready), .pc_write(pc_write), .id_write(id_write), .ex_write(ex_write),
    .m_write(m_write), .wb_write(wb_write), .ex_bubble(ex_bubble), .flush(flush),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .btb_write(btb_write),
    .btb_src(btb_src), .is_predict(is_predict), .fwd_a(fwd_a), .fwd_b(fwd_b), .state(state),
    .stall_cycles(stall_cycles), .flush_count(flush_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
  endtask

  function automatic logic [1:0] ref_fwd(input logic u, input logic [1:0] r);
    if (!u) return 2'd0;
    if (ex_regwrite && !ex_is_load && ex_dest == r) return 2'd1;
    if (m_regwrite && m_dest == r) return 2'd2;
    if (wb_regwrite && wb_dest == r) return 2'd3;
    return 2'd0;
  endfunction

  task automatic idle_inputs();
    {id_rs, id_rt, ex_dest, m_dest, wb_dest, id_ctl} = '0;
    {id_use_rs, id_use_rt, ex_regwrite, m_regwrite, wb_regwrite, ex_is_load, bcond} = '0;
    {predicted_pc, next_pc, br_target, jump_addr, jr_target} = '0;
    {i_ready, d_req, d_ready} = '0;
    {i_cache_hit, d_cache_hit} = 2'b11;
  endtask

  // evaluate the reference for the current inputs, compare every output, prepare next model state
  task automatic settle();
    bit dm, lu, mp, res;
    logic [15:0] act, e_rpc;
    logic [4:0] e_wr;
    bit e_bub, e_fl, e_rv, e_bw;
    logic [1:0] e_bs;
    #1;
    dm = d_req && !d_cache_hit;
    lu = ex_is_load && ex_regwrite && ((id_use_rs && id_rs == ex_dest) || (id_use_rt && id_rt == ex_dest));
    act = id_ctl == 2'd1 ? (bcond ? br_target : next_pc) : id_ctl == 2'd2 ? jump_addr : jr_target;
    mp = id_ctl != 2'd0 && predicted_pc != act;
    e_wr = 5'b11111; {e_bub, e_fl, e_rv, res} = '0; e_rpc = '0;
    {n_w_i, n_w_d, n_redir, n_frz, n_iseen, n_pv, n_pt} = {w_i, w_d, redir, frz, iseen, pv, pt};
    if (!reset_n) begin
      {n_w_i, n_w_d, n_redir, n_frz, n_iseen, n_pv} = '0;
      n_pt = '0;
    end else if (redir) begin
      {e_rv, e_fl} = 2'b11; e_rpc = pt; n_redir = 0; n_pv = 0;
    end else if (w_d) begin
      e_wr = 5'b00000; if (d_ready) n_w_d = 0;
    end else if (w_i) begin
      e_wr = 5'b00111; e_bub = 1;
      if (frz || dm) begin
        e_wr = 5'b00000; n_frz = frz ? !d_ready : 1'b1; n_iseen = iseen || i_ready;
      end else if (i_ready || iseen) begin
        n_w_i = 0; n_iseen = 0; n_redir = pv;
      end
    end else if (dm) begin
      e_wr = 5'b00000; n_w_d = 1;
    end else if (lu) begin
      e_wr = 5'b00111; e_bub = 1;
    end else begin
      res = 1;
      if (mp && i_cache_hit) begin e_fl = 1; e_rv = 1; e_rpc = act; end
      else if (mp) begin e_fl = 1; e_wr = 5'b01111; n_pv = 1; n_pt = act; n_w_i = 1; end
      else if (!i_cache_hit) begin e_wr = 5'b00111; e_bub = 1; n_w_i = 1; end
    end
    e_bw = res && (id_ctl == 2'd2 || id_ctl == 2'd3 || (id_ctl == 2'd1 && bcond));
    e_bs = id_ctl == 2'd1 ? (bcond ? 2'd0 : 2'd3) : id_ctl == 2'd3 ? 2'd1 : id_ctl == 2'd2 ? 2'd2 : 2'd0;
    chk("writes", 32'({pc_write, id_write, ex_write, m_write, wb_write}), 32'(e_wr));
    chk("ex_bubble", 32'(ex_bubble), 32'(e_bub));
    chk("flush", 32'(flush), 32'(e_fl));
    chk("redirect_valid", 32'(redirect_valid), 32'(e_rv));
    if (e_rv || !reset_n) chk("redirect_pc", 32'(redirect_pc), 32'(e_rpc));
    chk("btb_write", 32'(btb_write), 32'(e_bw));
    if (!reset_n) chk("btb_src_rst", 32'(btb_src), 32'd0);
    else if (res && id_ctl != 2'd0) chk("btb_src", 32'(btb_src), 32'(e_bs));
    chk("is_predict", 32'(is_predict), 32'(reset_n && id_ctl != 2'd0));
    chk("fwd_a", 32'(fwd_a), reset_n ? 32'(ref_fwd(id_use_rs, id_rs)) : 32'd0);
    chk("fwd_b", 32'(fwd_b), reset_n ? 32'(ref_fwd(id_use_rt, id_rt)) : 32'd0);
    chk("state", 32'(state), redir ? 32'd3 : w_d ? 32'd2 : w_i ? 32'd1 : 32'd0);
`ifdef HAZARD_PERF_CNT_EN
    chk("stall_cycles", 32'(stall_cycles), 32'(stall));
    chk("flush_count", 32'(flush_count), 32'(fl));
    n_stall = !reset_n ? 0 : (e_wr[4] == 1'b0 && stall < 65535) ? stall + 1 : stall;
    n_fl = !reset_n ? 0 : (e_fl && fl < 65535) ? fl + 1 : fl;
`else
    chk("stall_cycles", 32'(stall_cycles), 32'd0);
    chk("flush_count", 32'(flush_count), 32'd0);
    n_stall = 0; n_fl = 0;
`endif
  endtask

  task automatic tick();
    @(posedge clk);
    {w_i, w_d, redir, frz, iseen, pv, pt} = {n_w_i, n_w_d, n_redir, n_frz, n_iseen, n_pv, n_pt};
    stall = n_stall; fl = n_fl;
    @(negedge clk);
  endtask

  task automatic cycle();
    settle();
    tick();
  endtask

  initial begin
    reset_n = 1'b0;
    idle_inputs();
    repeat (2) @(posedge clk);
    @(negedge clk);
    repeat (2) cycle();
    reset_n = 1'b1;
    // EX-stage forwarding of an ALU result
    ex_dest = 2'd1; ex_regwrite = 1; id_rs = 2'd1; id_use_rs = 1;
    settle();
    chk("add_fwd_a", 32'(fwd_a), 32'd1);
    chk("add_writes", 32'({pc_write, id_write, ex_write, m_write, wb_write}), 32'h1f);
    tick();
    // load-use stall then MEM forwarding
    idle_inputs();
    ex_dest = 2'd2; ex_regwrite = 1; ex_is_load = 1; id_rt = 2'd2; id_use_rt = 1;
    settle();
    chk("lu_stall", 32'({pc_write, id_write, ex_bubble}), 32'b001);
    tick();
    idle_inputs();
    m_dest = 2'd2; m_regwrite = 1; id_rt = 2'd2; id_use_rt = 1;
    settle();
    chk("lu_fwd_b", 32'(fwd_b), 32'd2);
    tick();
    // taken branch mispredict, I-hit
    idle_inputs();
    id_ctl = 2'd1; bcond = 1; predicted_pc = 16'h0011; br_target = 16'h0020; next_pc = 16'h0012;
    settle();
    chk("br_hit_redirect", 32'({flush, redirect_valid, redirect_pc}), 32'h30020);
    chk("br_hit_btb", 32'({btb_write, btb_src}), 32'b100);
    tick();
    // same branch with I-miss: deferred redirect
    i_cache_hit = 0;
    cycle();
    chk("br_miss_wait_i", 32'(state), 32'd1);
    idle_inputs();
    repeat (4) cycle();
    i_ready = 1;
    cycle();
    i_ready = 0;
    settle();
    chk("br_miss_redirect", 32'({state, redirect_valid, redirect_pc}), 32'h70020);
    tick();
    chk("br_miss_back_run", 32'(state), 32'd0);
    // D-miss in RUN
    d_req = 1; d_cache_hit = 0;
    cycle();
    d_req = 0; d_cache_hit = 1;
    repeat (2) cycle();
    d_ready = 1;
    cycle();
    d_ready = 0;
    chk("dmiss_back_run", 32'(state), 32'd0);
    // D-miss with i_ready during WAIT_I
    i_cache_hit = 0;
    cycle();
    i_cache_hit = 1; d_req = 1; d_cache_hit = 0; i_ready = 1;
    cycle();
    d_req = 0; d_cache_hit = 1; i_ready = 0;
    repeat (2) cycle();
    d_ready = 1;
    cycle();
    d_ready = 0;
    chk("freeze_still_wait_i", 32'(state), 32'd1);
    cycle();
    chk("freeze_exit_run", 32'(state), 32'd0);
    // reset in the middle of WAIT_D
    d_req = 1; d_cache_hit = 0;
    cycle();
    d_req = 0; d_cache_hit = 1;
    cycle();
    reset_n = 0;
    cycle();
    chk("rst_mid_wait_d", 32'({state, stall_cycles, flush_count}), 32'd0);
    reset_n = 1; d_ready = 1;
    cycle();
    d_ready = 0;
    // randomized traffic
    for (int n = 0; n < 3000; n++) begin
      reset_n = $urandom_range(0, 59) != 0;
      {id_rs, id_rt, ex_dest, m_dest, wb_dest, id_ctl} = 12'($urandom);
      {id_use_rs, id_use_rt, ex_regwrite, m_regwrite, wb_regwrite, bcond} = 6'($urandom);
      ex_is_load = $urandom_range(0, 3) == 0;
      next_pc = 16'($urandom_range(0, 7));
      br_target = 16'($urandom_range(0, 7));
      jump_addr = 16'($urandom_range(0, 7));
      jr_target = 16'($urandom_range(0, 7));
      predicted_pc = $urandom_range(0, 1) ? (id_ctl == 2'd1 ? (bcond ? br_target : next_pc) :
                     id_ctl == 2'd2 ? jump_addr : jr_target) : 16'($urandom_range(0, 7));
      i_cache_hit = $urandom_range(0, 3) != 0;
      i_ready = $urandom_range(0, 2) == 0;
      d_req = $urandom_range(0, 2) == 0;
      d_cache_hit = $urandom_range(0, 4) != 0;
      d_ready = $urandom_range(0, 2) == 0;
      cycle();
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
